// File: rtl/hwpe_stream_addressgen_3d.sv
// 3-level strided word-address generator (d0 word, d1 line, d2 block) feeding TCDM request logic.
// Latency 1 from start to first address; addr_o held while addr_valid_o & !addr_ready_i.
package hwpe_stream_addressgen_3d_pkg;

  typedef struct packed {
    logic [31:0] base_addr;
    logic [31:0] tot_len;
    logic [31:0] d0_len;
    logic [31:0] d0_stride;
    logic [31:0] d1_len;
    logic [31:0] d1_stride;
    logic [31:0] d2_stride;
    logic [1:0]  dim_enable_1h;
  } ctrl_addressgen_v3_t;

  typedef struct packed {
    logic done;
  } flags_addressgen_v3_t;

endpackage

module hwpe_stream_addressgen_3d
  import hwpe_stream_addressgen_3d_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned CNT_WIDTH  = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  enable_i,
  input  logic                  clear_i,
  input  logic                  start_i,
  input  ctrl_addressgen_v3_t   ctrl_i,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic                  addr_valid_o,
  input  logic                  addr_ready_i,
  output logic                  busy_o,
  output flags_addressgen_v3_t  flags_o
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t                state_q, state_d;
  ctrl_addressgen_v3_t   ctrl_q, ctrl_d;
  logic [CNT_WIDTH-1:0]  tot_cnt_q, tot_cnt_d;
  logic [CNT_WIDTH-1:0]  d0_cnt_q, d0_cnt_d;
  logic [CNT_WIDTH-1:0]  d1_cnt_q, d1_cnt_d;
  logic [31:0]           off_d0_q, off_d0_d;
  logic [31:0]           off_d1_q, off_d1_d;
  logic [31:0]           off_d2_q, off_d2_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;

  logic [CNT_WIDTH-1:0]  tot_len, d0_len, d1_len, start_tot_len;
  logic [CNT_WIDTH:0]    tot_nxt, d0_nxt, d1_nxt;
  logic                  accept, last, d0_more, d1_more;
  logic [31:0]           addr_sum;

  assign tot_len       = ctrl_q.tot_len[CNT_WIDTH-1:0];
  assign d0_len        = ctrl_q.d0_len[CNT_WIDTH-1:0];
  assign d1_len        = ctrl_q.d1_len[CNT_WIDTH-1:0];
  assign start_tot_len = ctrl_i.tot_len[CNT_WIDTH-1:0];

  // Counters compared one bit wider so cnt+1 never wraps; a length of 0 then behaves as 1.
  assign tot_nxt = {1'b0, tot_cnt_q} + {{CNT_WIDTH{1'b0}}, 1'b1};
  assign d0_nxt  = {1'b0, d0_cnt_q} + {{CNT_WIDTH{1'b0}}, 1'b1};
  assign d1_nxt  = {1'b0, d1_cnt_q} + {{CNT_WIDTH{1'b0}}, 1'b1};

  assign accept  = (state_q == RUN) && enable_i && addr_ready_i;
  assign last    = (tot_nxt == {1'b0, tot_len});
  assign d0_more = (d0_nxt < {1'b0, d0_len}) || !ctrl_q.dim_enable_1h[0];
  assign d1_more = (d1_nxt < {1'b0, d1_len}) || !ctrl_q.dim_enable_1h[1];

  assign addr_sum = ctrl_q.base_addr + off_d0_d + off_d1_d + off_d2_d;

  always_comb begin
    state_d   = state_q;
    ctrl_d    = ctrl_q;
    tot_cnt_d = tot_cnt_q;
    d0_cnt_d  = d0_cnt_q;
    d1_cnt_d  = d1_cnt_q;
    off_d0_d  = off_d0_q;
    off_d1_d  = off_d1_q;
    off_d2_d  = off_d2_q;
    addr_d    = addr_q;

    case (state_q)
      IDLE: begin
        if (start_i && enable_i) begin
          ctrl_d    = ctrl_i;
          tot_cnt_d = '0;
          d0_cnt_d  = '0;
          d1_cnt_d  = '0;
          off_d0_d  = '0;
          off_d1_d  = '0;
          off_d2_d  = '0;
          addr_d    = ctrl_i.base_addr[ADDR_WIDTH-1:0];
          state_d   = (start_tot_len == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (accept) begin
          tot_cnt_d = tot_nxt[CNT_WIDTH-1:0];
          if (d0_more) begin
            d0_cnt_d = d0_nxt[CNT_WIDTH-1:0];
            off_d0_d = off_d0_q + ctrl_q.d0_stride;
          end else begin
            d0_cnt_d = '0;
            off_d0_d = '0;
            if (d1_more) begin
              d1_cnt_d = d1_nxt[CNT_WIDTH-1:0];
              off_d1_d = off_d1_q + ctrl_q.d1_stride;
            end else begin
              d1_cnt_d = '0;
              off_d1_d = '0;
              off_d2_d = off_d2_q + ctrl_q.d2_stride;
            end
          end
          // After the last accept the output is no longer valid, so its value is irrelevant.
          if (last) begin
            state_d = DONE;
          end else begin
            addr_d = addr_sum[ADDR_WIDTH-1:0];
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (clear_i) begin
      state_d   = IDLE;
      ctrl_d    = '0;
      tot_cnt_d = '0;
      d0_cnt_d  = '0;
      d1_cnt_d  = '0;
      off_d0_d  = '0;
      off_d1_d  = '0;
      off_d2_d  = '0;
      addr_d    = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      ctrl_q    <= '0;
      tot_cnt_q <= '0;
      d0_cnt_q  <= '0;
      d1_cnt_q  <= '0;
      off_d0_q  <= '0;
      off_d1_q  <= '0;
      off_d2_q  <= '0;
      addr_q    <= '0;
    end else begin
      state_q   <= state_d;
      ctrl_q    <= ctrl_d;
      tot_cnt_q <= tot_cnt_d;
      d0_cnt_q  <= d0_cnt_d;
      d1_cnt_q  <= d1_cnt_d;
      off_d0_q  <= off_d0_d;
      off_d1_q  <= off_d1_d;
      off_d2_q  <= off_d2_d;
      addr_q    <= addr_d;
    end
  end

  assign addr_o       = addr_q;
  assign addr_valid_o = (state_q == RUN);
  assign busy_o       = (state_q != IDLE);
  assign flags_o.done = (state_q == DONE);

endmodule
